// File: rtl/vending_machine_multi_pkg.sv
// vending_machine_multi_pkg: shared FSM state encoding for the multi-item vending controller
package vending_machine_multi_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_e;
endpackage

// File: rtl/vm_stock_bank.sv
// vm_stock_bank: per-item stock counters with saturating restock and guarded decrement
// Ports: clk/reset (async active-low); dec_en/dec_idx remove one unit; inc_en/inc_idx/inc_qty
//        add units (saturating); stock_o packed counters (item0 in LSBs); empty_o per-item zero flags.
module vm_stock_bank #(
  parameter int NUM_ITEMS  = 4,
  parameter int SEL_W      = 2,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dec_en,
  input  logic [SEL_W-1:0]             dec_idx,
  input  logic                         inc_en,
  input  logic [SEL_W-1:0]             inc_idx,
  input  logic [STOCK_W-1:0]           inc_qty,
  output logic [NUM_ITEMS*STOCK_W-1:0] stock_o,
  output logic [NUM_ITEMS-1:0]         empty_o
);
  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_item
    logic [STOCK_W-1:0] stock_q, stock_d;
    logic [STOCK_W:0]   sum;
    always_comb begin
      sum     = {1'b0, stock_q} + {1'b0, inc_qty};
      stock_d = stock_q;
      if (inc_en && inc_idx == SEL_W'(g))
        stock_d = sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
      else if (dec_en && dec_idx == SEL_W'(g) && stock_q != '0)
        stock_d = stock_q - 1'b1;
    end
    always_ff @(posedge clk or negedge reset)
      if (!reset) stock_q <= STOCK_W'(INIT_STOCK);
      else        stock_q <= stock_d;
    assign stock_o[g*STOCK_W +: STOCK_W] = stock_q;
    assign empty_o[g] = (stock_q == '0);
  end
endmodule

// File: rtl/vending_machine_multi.sv
// vending_machine_multi: multi-item vending controller with credit, change, refund and restock
// Ports: clk, reset (async active-low); coin_valid/coin_value; select_valid/item_sel; cancel;
//        restock_valid/restock_item/restock_qty; credit; dispense/dispense_item;
//        change_valid/change_amount; coin_reject; sold_out; insufficient; busy.
module vending_machine_multi
  import vending_machine_multi_pkg::*;
#(
  parameter int                          NUM_ITEMS  = 4,
  parameter int                          SEL_W      = 2,
  parameter int                          COIN_W     = 4,
  parameter int                          CREDIT_W   = 6,
  parameter int                          PRICE_W    = 5,
  parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICE_LIST = {5'd12, 5'd10, 5'd8, 5'd5},
  parameter int                          STOCK_W    = 4,
  parameter int                          INIT_STOCK = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_value,
  input  logic                select_valid,
  input  logic [SEL_W-1:0]    item_sel,
  input  logic                cancel,
  input  logic                restock_valid,
  input  logic [SEL_W-1:0]    restock_item,
  input  logic [STOCK_W-1:0]  restock_qty,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic [SEL_W-1:0]    dispense_item,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic                coin_reject,
  output logic                sold_out,
  output logic                insufficient,
  output logic                busy
);
  state_e                         state_q, state_d;
  logic [CREDIT_W-1:0]            credit_q, credit_d, change_amount_q, change_amount_d;
  logic [SEL_W-1:0]               sel_q, sel_d, dispense_item_q, dispense_item_d;
  logic                           dispense_q, dispense_d, change_valid_q, change_valid_d;
  logic                           coin_reject_q, coin_reject_d, sold_out_q, sold_out_d;
  logic                           insufficient_q, insufficient_d;
  logic [PRICE_W-1:0]             prices [NUM_ITEMS];
  logic [NUM_ITEMS-1:0]           empty;
  logic [NUM_ITEMS*STOCK_W-1:0]   unused_stock_vec;
  logic                           dec_en, inc_en, afford, coin_ovf;
  logic [CREDIT_W:0]              coin_sum;
  logic [CREDIT_W-1:0]            remainder;

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_price
    assign prices[g] = PRICE_LIST[g*PRICE_W +: PRICE_W];
  end

  // One extra bit so an overflowing coin is detected instead of wrapping the credit.
  assign coin_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value);
  assign coin_ovf  = coin_sum[CREDIT_W];
  assign afford    = {1'b0, credit_q} >= (CREDIT_W+1)'(prices[item_sel]);
  assign remainder = credit_q - CREDIT_W'(prices[sel_q]);

  vm_stock_bank #(
    .NUM_ITEMS (NUM_ITEMS),
    .SEL_W     (SEL_W),
    .STOCK_W   (STOCK_W),
    .INIT_STOCK(INIT_STOCK)
  ) u_bank (
    .clk    (clk),
    .reset  (reset),
    .dec_en (dec_en),
    .dec_idx(sel_q),
    .inc_en (inc_en),
    .inc_idx(restock_item),
    .inc_qty(restock_qty),
    .stock_o(unused_stock_vec),
    .empty_o(empty)
  );

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    sel_d           = sel_q;
    dispense_d      = 1'b0;
    dispense_item_d = '0;
    change_valid_d  = 1'b0;
    change_amount_d = '0;
    coin_reject_d   = 1'b0;
    sold_out_d      = 1'b0;
    insufficient_d  = 1'b0;
    dec_en          = 1'b0;
    inc_en          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        insufficient_d = select_valid;
        inc_en         = restock_valid;
        if (coin_valid) begin
          credit_d = CREDIT_W'(coin_value);
          state_d  = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        if (cancel) begin
          state_d       = ST_CHANGE;
          coin_reject_d = coin_valid;
        end else if (select_valid && !empty[item_sel] && afford) begin
          state_d       = ST_VEND;
          sel_d         = item_sel;
          coin_reject_d = coin_valid;
        end else begin
          // A refused select still lets a same-cycle coin through.
          sold_out_d     = select_valid && empty[item_sel];
          insufficient_d = select_valid && !empty[item_sel] && !afford;
          if (coin_valid) begin
            coin_reject_d = coin_ovf;
            credit_d      = coin_ovf ? credit_q : coin_sum[CREDIT_W-1:0];
          end
        end
      end
      ST_VEND: begin
        coin_reject_d   = coin_valid;
        dispense_d      = 1'b1;
        dispense_item_d = sel_q;
        dec_en          = 1'b1;
        credit_d        = remainder;
        state_d         = (remainder != '0) ? ST_CHANGE : ST_IDLE;
      end
      default: begin
        coin_reject_d   = coin_valid;
        change_valid_d  = 1'b1;
        change_amount_d = credit_q;
        credit_d        = '0;
        state_d         = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      credit_q        <= '0;
      sel_q           <= '0;
      dispense_q      <= 1'b0;
      dispense_item_q <= '0;
      change_valid_q  <= 1'b0;
      change_amount_q <= '0;
      coin_reject_q   <= 1'b0;
      sold_out_q      <= 1'b0;
      insufficient_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      sel_q           <= sel_d;
      dispense_q      <= dispense_d;
      dispense_item_q <= dispense_item_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
      coin_reject_q   <= coin_reject_d;
      sold_out_q      <= sold_out_d;
      insufficient_q  <= insufficient_d;
    end
  end

  assign credit        = credit_q;
  assign dispense      = dispense_q;
  assign dispense_item = dispense_item_q;
  assign change_valid  = change_valid_q;
  assign change_amount = change_amount_q;
  assign coin_reject   = coin_reject_q;
  assign sold_out      = sold_out_q;
  assign insufficient  = insufficient_q;
  assign busy          = (state_q == ST_VEND) || (state_q == ST_CHANGE);
endmodule
